// File: rtl/gp9001_cmd_arb_pkg.sv
// Shared definitions for the GP9001 command arbiter.
// Contents:
//   OP_*            3-bit requester operation codes (6 and 7 are invalid)
//   arb_state_e     arbiter FSM state encoding
//   ABORT_DATA      read data returned to a requester whose command timed out
//   op_valid()      1 for a legal operation code
//   op_is_read()    1 for the operations that return GP9001 read data
//   op_strobe()     one-hot strobe vector for an operation, zero if invalid
package gp9001_arb_pkg;

   localparam logic [2:0] OP_SELECT_REG  = 3'd0;
   localparam logic [2:0] OP_WRITE_REG   = 3'd1;
   localparam logic [2:0] OP_WRITE_RAM   = 3'd2;
   localparam logic [2:0] OP_READ_RAM_H  = 3'd3;
   localparam logic [2:0] OP_READ_RAM_L  = 3'd4;
   localparam logic [2:0] OP_SET_RAM_PTR = 3'd5;

   localparam logic [15:0] ABORT_DATA = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DONE  = 2'd2,
      ST_FLUSH = 2'd3
   } arb_state_e;

   function automatic logic op_valid(input logic [2:0] op);
      return op <= OP_SET_RAM_PTR;
   endfunction

   function automatic logic op_is_read(input logic [2:0] op);
      return (op == OP_READ_RAM_H) || (op == OP_READ_RAM_L);
   endfunction

   // Bit n of the result is the strobe for op code n; codes 6 and 7 shift
   // the single set bit out of the 6-bit vector, so they yield no strobe.
   function automatic logic [5:0] op_strobe(input logic [2:0] op);
      return 6'd1 << op;
   endfunction

endpackage

// File: rtl/gp9001_cmd_arb_if.sv
// GP9001 command bus between the arbiter (master) and the video chip (slave).
// Signals:
//   GP9001_OP_*    command strobes, at most one high, held for the whole command
//   GP9001_DIN     write data presented with the strobe
//   GP9001_DOUT    read data from the GP9001
//   GP9001ACK      level completion from the GP9001
interface gp9001_cmd_arb_if;
   logic        GP9001_OP_SELECT_REG;
   logic        GP9001_OP_WRITE_REG;
   logic        GP9001_OP_WRITE_RAM;
   logic        GP9001_OP_READ_RAM_H;
   logic        GP9001_OP_READ_RAM_L;
   logic        GP9001_OP_SET_RAM_PTR;
   logic [15:0] GP9001_DIN;
   logic [15:0] GP9001_DOUT;
   logic        GP9001ACK;

   modport master (
      output GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM,
             GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR,
             GP9001_DIN,
      input  GP9001_DOUT, GP9001ACK
   );

   modport slave (
      input  GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM,
             GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR,
             GP9001_DIN,
      output GP9001_DOUT, GP9001ACK
   );
endinterface

// File: rtl/gp9001_cmd_arb_rr.sv
// Two-way round-robin arbiter with a priority override for requester 1.
// Ports:
//   req[1:0]   pending requests
//   prio1      when high, requester 1 wins whenever it is requesting
//   last       index of the requester granted most recently
//   gnt[1:0]   one-hot grant (zero when nothing is requesting)
module gp9001_rr_arb (
   input  logic [1:0] req,
   input  logic       prio1,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = 2'b00;
      if (prio1 && req[1])
         gnt = 2'b10;
      else if (req == 2'b11)
         gnt = last ? 2'b01 : 2'b10;
      else
         gnt = req;
   end
endmodule

// File: rtl/gp9001_cmd_arb.sv
// Arbitrates two requesters onto the single GP9001 command bus.
// Ports:
//   CLK96, RESET96     96 MHz clock, asynchronous active-high reset
//   REQ0/1, OP0/1      level requests and their operation codes
//   DIN0/1             write data per requester
//   ACK0/1             one-cycle completion pulse per requester
//   RDATA0/1           read result per requester, held until its next completion
//   LVBL               low during vertical blank (enables requester-1 priority)
//   BUSY               high whenever a command is in progress
//   TIMEOUT_ERR        sticky flag, set when a command is aborted
//   gp                 GP9001 command bus (master side)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no command; arbitrate and latch the winner's OP/DIN
// ST_WAIT  | strobe high, waiting for GP9001ACK or the timeout
// ST_DONE  | command finished; ACK on first cycle, wait for GP9001ACK low
// ST_FLUSH | command aborted by timeout; ACK for one cycle, then ST_DONE
module gp9001_cmd_arb #(
   parameter logic [7:0] TIMEOUT_CYC = 8'd255,
   parameter logic       PRIO_VBL    = 1'b1
) (
   input  logic        CLK96,
   input  logic        RESET96,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [2:0]  OP0,
   input  logic [2:0]  OP1,
   input  logic [15:0] DIN0,
   input  logic [15:0] DIN1,
   output logic        ACK0,
   output logic        ACK1,
   output logic [15:0] RDATA0,
   output logic [15:0] RDATA1,
   input  logic        LVBL,
   output logic        BUSY,
   output logic        TIMEOUT_ERR,
   gp9001_cmd_arb_if.master gp
);
   import gp9001_arb_pkg::*;

   arb_state_e  state_q, state_d;
   logic        last_q;
   logic        port_q;
   logic [2:0]  op_q;
   logic [15:0] din_q;
   logic [15:0] rdata0_q, rdata1_q;
   logic        err_q;
   logic [7:0]  cnt_q;
   logic        first_q;

   logic [1:0]  gnt;
   logic        gnt_any;
   logic        prio1;
   logic [2:0]  op_gnt;
   logic [15:0] din_gnt;
   logic [7:0]  cnt_inc;
   logic        to_hit;
   logic        first_d;

   logic        rd_we;
   logic        rd_port;
   logic [15:0] rd_val;

   logic [5:0]  strobe;
   logic        ack_pulse;

   assign prio1   = PRIO_VBL & ~LVBL;
   assign gnt_any = |gnt;
   assign op_gnt  = gnt[1] ? OP1 : OP0;
   assign din_gnt = gnt[1] ? DIN1 : DIN0;
   // The counter holds the number of completed WAIT cycles, so the abort
   // fires in the WAIT cycle whose count would reach TIMEOUT_CYC.
   assign cnt_inc = cnt_q + 8'd1;
   assign to_hit  = (cnt_inc == TIMEOUT_CYC);

   gp9001_rr_arb u_rr (
      .req   ({REQ1, REQ0}),
      .prio1 (prio1),
      .last  (last_q),
      .gnt   (gnt)
   );

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (gnt_any)
               state_d = op_valid(op_gnt) ? ST_WAIT : ST_DONE;
         ST_WAIT:
            // completion wins over a timeout landing in the same cycle
            if (gp.GP9001ACK)
               state_d = ST_DONE;
            else if (to_hit)
               state_d = ST_FLUSH;
         ST_FLUSH:
            state_d = ST_DONE;
         ST_DONE:
            if (!gp.GP9001ACK)
               state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      strobe    = '0;
      ack_pulse = 1'b0;
      case (state_q)
         ST_WAIT:  strobe    = op_strobe(op_q);
         ST_DONE:  ack_pulse = first_q;
         ST_FLUSH: ack_pulse = 1'b1;
         default:  ;
      endcase
      BUSY = (state_q != ST_IDLE);
      ACK0 = ack_pulse & ~port_q;
      ACK1 = ack_pulse & port_q;
   end

   // RDATA update and first-DONE marker. ST_DONE reached through ST_FLUSH
   // has already acknowledged, so only direct entries mark the first cycle.
   always_comb begin
      rd_we   = 1'b0;
      rd_port = port_q;
      rd_val  = gp.GP9001_DOUT;
      first_d = 1'b0;
      case (state_q)
         ST_IDLE:
            if (gnt_any && !op_valid(op_gnt)) begin
               rd_we   = 1'b1;
               rd_port = gnt[1];
               rd_val  = 16'h0000;
               first_d = 1'b1;
            end
         ST_WAIT:
            if (gp.GP9001ACK) begin
               rd_we   = op_is_read(op_q);
               first_d = 1'b1;
            end else if (to_hit) begin
               rd_we   = 1'b1;
               rd_val  = ABORT_DATA;
            end
         default: ;
      endcase
   end

   always_ff @(posedge CLK96 or posedge RESET96) begin
      if (RESET96) begin
         last_q   <= 1'b1;
         port_q   <= 1'b0;
         op_q     <= 3'd0;
         din_q    <= 16'h0000;
         rdata0_q <= 16'h0000;
         rdata1_q <= 16'h0000;
         err_q    <= 1'b0;
         cnt_q    <= 8'd0;
         first_q  <= 1'b0;
      end else begin
         first_q <= first_d;
         if (state_q == ST_IDLE && gnt_any) begin
            last_q <= gnt[1];
            port_q <= gnt[1];
            op_q   <= op_gnt;
            din_q  <= din_gnt;
            cnt_q  <= 8'd0;
         end
         if (state_q == ST_WAIT) begin
            cnt_q <= cnt_inc;
            if (!gp.GP9001ACK && to_hit)
               err_q <= 1'b1;
         end
         if (rd_we) begin
            if (rd_port)
               rdata1_q <= rd_val;
            else
               rdata0_q <= rd_val;
         end
      end
   end

   assign gp.GP9001_OP_SELECT_REG  = strobe[0];
   assign gp.GP9001_OP_WRITE_REG   = strobe[1];
   assign gp.GP9001_OP_WRITE_RAM   = strobe[2];
   assign gp.GP9001_OP_READ_RAM_H  = strobe[3];
   assign gp.GP9001_OP_READ_RAM_L  = strobe[4];
   assign gp.GP9001_OP_SET_RAM_PTR = strobe[5];
   assign gp.GP9001_DIN            = din_q;

   assign RDATA0      = rdata0_q;
   assign RDATA1      = rdata1_q;
   assign TIMEOUT_ERR = err_q;

endmodule
